ps2_host_transmitter: RTL and testbench
=======================================

Name: ps2_host_transmitter

Overview:
Host-to-device side of the PS/2 link. Sends single command bytes to the keyboard, such as LED set (0xED) or enable (0xF4), over the same ps2_clk/ps2_data pair that the keyboard receive path listens on. It drives both lines open-drain through active-high pull-low enables and follows the PS/2 host request-to-send sequence. It checks the device ACK and reports done or error to the game control logic.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before request-to-send (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, max clk cycles from clock release to ACK completion (15 ms at 50 MHz).

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
ps2_clk  input  1  raw PS/2 clock line state (asynchronous)
ps2_data  input  1  raw PS/2 data line state (asynchronous)
ps2_clk_low  output  1  1 = pull PS/2 clock low; 0 = release (high-Z)
ps2_data_low  output  1  1 = pull PS/2 data low; 0 = release (high-Z)
tx_data  input  8  command byte; sampled when a start is accepted
tx_start  input  1  request to send; accepted only in IDLE
tx_busy  output  1  high from the accept cycle until the done pulse, inclusive
tx_done  output  1  one-cycle pulse at the end of every accepted transfer
tx_error  output  1  valid with tx_done; 1 = no ACK or timeout; holds until the next accept

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0 on the next clk edge and both lines are released.
  - State goes to IDLE; counters and shift register clear.
  - This applies mid-transfer too, with no done pulse.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - A falling edge is a synchronized clock sample of 1 followed by 0.
  - All protocol decisions use the synchronized values.
- Frame format: start bit 0, data bits D0..D7 LSB first, odd parity (parity = ~^tx_data), stop bit 1 (line released).
- FSM:
  - IDLE: lines released, tx_busy=0. If tx_start=1, latch tx_data, compute parity and go to INHIBIT. tx_busy rises that same edge.
  - INHIBIT: ps2_clk_low=1 for exactly INHIBIT_CYCLES cycles. In the final cycle also set ps2_data_low=1, then go to REQ.
  - REQ: release the clock and hold data low (start bit). Clear the timeout counter and bit counter. The first falling edge goes to SEND.
  - SEND: on each falling edge, drive the next bit: ps2_data_low = ~bit.
    - Falling edges 1..8 drive D0..D7.
    - Falling edge 9 drives parity.
    - Falling edge 10 releases data (stop bit) and goes to ACK.
  - ACK: on the next falling edge, sample synchronized data. 0 = ACK OK; 1 = error. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synchronized clock and data are both 1 for one cycle. Then pulse tx_done, drive tx_error, drop tx_busy in the following cycle, and return to IDLE.
- Timeout:
  - The counter runs in REQ, SEND, ACK and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES: release both lines, pulse tx_done with tx_error=1, and return to IDLE in the next cycle.
  - Timeout takes priority over a falling edge in the same cycle.
- tx_start while busy is ignored and not queued.
- tx_start held high across a done pulse starts a new transfer from IDLE on the first IDLE cycle.
- The bit counter is 4 bits; no wrap is reachable, because ACK exits at edge 10.
- ps2_clk_low and ps2_data_low are never asserted in IDLE.

Test Plan:
- tx_data=0xED, BFM device model clocks 11 falling edges with ACK=0:
  - ps2_clk_low high for 5000 cycles (INHIBIT_CYCLES=5000).
  - Captured frame: start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done with tx_error=0.
- tx_data=0xF4: parity bit 0. tx_data=0x00: parity 1. Frames match bit for bit; tx_error=0.
- Device releases data at ACK (data=1 on the 11th falling edge) -> tx_done with tx_error=1, both lines released.
- Device never clocks after REQ, with TIMEOUT_CYCLES=2000 for the test -> tx_done/tx_error=1 exactly 2000 cycles after clock release; lines released; IDLE.
- rst=1 during SEND bit 4 -> next edge: ps2_clk_low=0, ps2_data_low=0, tx_busy=0, no tx_done. A new tx_start=0x55 then completes normally.
- tx_start pulsed during INHIBIT with a different tx_data -> ignored; transmitted byte equals the originally latched value.

Source files
------------

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clocked-out frame,
// device ACK check and a whole-transfer timeout. Lines are driven open-drain via pull-low enables.
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_low,
    output logic       ps2_data_low,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE} state_t;

    state_t        state, state_n;
    logic [IW-1:0] inh_cnt, inh_cnt_n;
    logic [TW-1:0] tmo_cnt, tmo_cnt_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [8:0]    shreg, shreg_n;
    logic          clk_low_n, data_low_n, busy_n, done_n, error_n;

    logic clk_meta, clk_sync, clk_prev, data_meta, data_sync;
    logic fall;

    // Idle bus is high, so synchronizers reset to 1 to avoid a phantom falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    assign fall = clk_prev & ~clk_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            inh_cnt      <= '0;
            tmo_cnt      <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            ps2_clk_low  <= 1'b0;
            ps2_data_low <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            tx_error     <= 1'b0;
        end else begin
            state        <= state_n;
            inh_cnt      <= inh_cnt_n;
            tmo_cnt      <= tmo_cnt_n;
            bit_cnt      <= bit_cnt_n;
            shreg        <= shreg_n;
            ps2_clk_low  <= clk_low_n;
            ps2_data_low <= data_low_n;
            tx_busy      <= busy_n;
            tx_done      <= done_n;
            tx_error     <= error_n;
        end
    end

    always_comb begin
        state_n    = state;
        inh_cnt_n  = inh_cnt;
        tmo_cnt_n  = tmo_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        clk_low_n  = ps2_clk_low;
        data_low_n = ps2_data_low;
        busy_n     = tx_busy;
        done_n     = 1'b0;
        error_n    = tx_error;
        case (state)
            IDLE: begin
                clk_low_n  = 1'b0;
                data_low_n = 1'b0;
                busy_n     = 1'b0;
                if (tx_start) begin
                    state_n   = INHIBIT;
                    shreg_n   = {~^tx_data, tx_data};
                    inh_cnt_n = '0;
                    clk_low_n = 1'b1;
                    busy_n    = 1'b1;
                    error_n   = 1'b0;
                end
            end
            INHIBIT: begin
                inh_cnt_n = inh_cnt + 1'b1;
                // Data goes low one cycle before the clock is released.
                if (inh_cnt == IW'(INHIBIT_CYCLES - 2))
                    data_low_n = 1'b1;
                if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                    state_n    = REQ;
                    clk_low_n  = 1'b0;
                    data_low_n = 1'b1;
                    tmo_cnt_n  = '0;
                    bit_cnt_n  = '0;
                end
            end
            REQ, SEND, ACK, WAIT_IDLE: begin
                tmo_cnt_n = tmo_cnt + 1'b1;
                if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_n    = DONE;
                    clk_low_n  = 1'b0;
                    data_low_n = 1'b0;
                    done_n     = 1'b1;
                    error_n    = 1'b1;
                end else begin
                    case (state)
                        REQ: if (fall) begin
                            data_low_n = ~shreg[0];
                            shreg_n    = {1'b1, shreg[8:1]};
                            bit_cnt_n  = 4'd1;
                            state_n    = SEND;
                        end
                        SEND: if (fall) begin
                            if (bit_cnt == 4'd9) begin
                                data_low_n = 1'b0;
                                state_n    = ACK;
                            end else begin
                                data_low_n = ~shreg[0];
                                shreg_n    = {1'b1, shreg[8:1]};
                                bit_cnt_n  = bit_cnt + 4'd1;
                            end
                        end
                        ACK: if (fall) begin
                            error_n = data_sync;
                            state_n = WAIT_IDLE;
                        end
                        WAIT_IDLE: if (clk_sync && data_sync) begin
                            done_n  = 1'b1;
                            state_n = DONE;
                        end
                        default: ;
                    endcase
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: a device BFM clocks frames out of the host, a scoreboard
// checks every done pulse against a frame/parity model computed from the byte value.
module tb_ps2_host_transmitter;
    localparam int INH = 5000;
    localparam int TMO = 2000;
    localparam int HP  = 15;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
        logic       chk_frame;
        logic       tmo;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       ps2_clk_low, ps2_data_low, tx_busy, tx_done, tx_error;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    logic       clk_line, data_line;

    assign clk_line  = ~(ps2_clk_low | dev_clk_low);
    assign data_line = ~(ps2_data_low | dev_data_low);

    ps2_host_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(clk_line), .ps2_data(data_line),
        .ps2_clk_low(ps2_clk_low), .ps2_data_low(ps2_data_low),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        int ones = 0;
        logic par;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        par = (ones % 2 == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    // Line activity tracking: inhibit length, data-low overlap, clock release time.
    int   inh_run = 0, inh_dl = 0, inh_last = 0, inh_dl_last = 0, rel_cyc = 0;
    logic prev_cl = 1'b0;
    always @(negedge clk) begin
        prev_cl <= ps2_clk_low;
        if (prev_cl === 1'b1 && ps2_clk_low === 1'b0) rel_cyc <= cyc;
        if (ps2_clk_low === 1'b1) begin
            inh_run <= inh_run + 1;
            inh_dl  <= inh_dl + ((ps2_data_low === 1'b1) ? 1 : 0);
        end else if (inh_run != 0) begin
            inh_last    <= inh_run;
            inh_dl_last <= inh_dl;
            inh_run     <= 0;
            inh_dl      <= 0;
        end
    end

    exp_t        expq[$];
    int          done_count = 0;
    logic [10:0] cap_frame = '0;

    always @(negedge clk) begin
        exp_t e;
        if (tx_done === 1'b1) begin
            if (expq.size() == 0) begin
                check("spurious_done", 32'(tx_done), 0);
            end else begin
                e = expq.pop_front();
                check("tx_error", 32'(tx_error), 32'(e.err));
                check("busy_at_done", 32'(tx_busy), 1);
                check("clk_released", 32'(ps2_clk_low), 0);
                check("data_released", 32'(ps2_data_low), 0);
                if (e.chk_frame) check("frame", 32'(cap_frame), 32'(frame_of(e.data)));
                if (e.tmo) check("timeout_latency", cyc - rel_cyc, TMO);
            end
            done_count <= done_count + 1;
        end
    end

    task automatic start(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_on_accept", 32'(tx_busy), 1);
    endtask

    // Device BFM: waits for request-to-send, then clocks the frame, sampling on rising edges.
    task automatic device(input logic ack_ok, input int npulses);
        int n = 0;
        while (!(clk_line === 1'b1 && data_line === 1'b0) && n < INH + 500) begin
            @(negedge clk);
            n++;
        end
        if (!(clk_line === 1'b1 && data_line === 1'b0)) begin
            check("request_seen", 32'(clk_line & ~data_line), 1);
            return;
        end
        repeat (3) @(negedge clk);
        cap_frame[0] = data_line;
        for (int i = 1; i <= 10; i++) begin
            if (i > npulses) return;
            dev_clk_low = 1'b1;
            repeat (HP) @(negedge clk);
            dev_clk_low = 1'b0;
            cap_frame[i] = data_line;
            repeat (HP) @(negedge clk);
        end
        dev_data_low = ack_ok;
        repeat (HP / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HP) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HP) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input int target, input int bound);
        int n = 0;
        while (done_count <= target && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (done_count <= target) check("done_wait", done_count, target + 1);
        @(negedge clk);
        check("busy_after_done", 32'(tx_busy), 0);
    endtask

    task automatic xfer(input logic [7:0] d, input logic ack_ok);
        int target = done_count;
        expq.push_back('{d, ~ack_ok, 1'b1, 1'b0});
        cap_frame = '0;
        start(d);
        device(ack_ok, 10);
        wait_done(target, 3000);
    endtask

    initial begin
        int target;
        logic [7:0] d;
        repeat (4) @(negedge clk);
        check("reset_outputs", 32'({tx_busy, tx_done, tx_error, ps2_clk_low, ps2_data_low}), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        xfer(8'hED, 1'b1);
        check("inhibit_len", inh_last, INH);
        check("inhibit_data_low_cycles", inh_dl_last, 1);
        xfer(8'hF4, 1'b1);
        xfer(8'h00, 1'b1);
        xfer(8'h96, 1'b0);

        // Device never clocks: timeout counted from clock release.
        target = done_count;
        expq.push_back('{8'h3A, 1'b1, 1'b0, 1'b1});
        start(8'h3A);
        wait_done(target, INH + TMO + 300);

        // Reset in the middle of SEND: lines drop, no done pulse.
        cap_frame = '0;
        start(8'hC3);
        device(1'b1, 4);
        check("busy_before_rst", 32'(tx_busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", 32'({ps2_clk_low, ps2_data_low, tx_busy, tx_done}), 0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("idle_after_rst", 32'({tx_busy, ps2_clk_low, ps2_data_low}), 0);
        xfer(8'h55, 1'b1);

        // Start request during INHIBIT with new data must be ignored.
        target = done_count;
        expq.push_back('{8'hA5, 1'b0, 1'b1, 1'b0});
        cap_frame = '0;
        start(8'hA5);
        repeat (100) @(negedge clk);
        tx_data  = 8'h5A;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        device(1'b1, 10);
        wait_done(target, 3000);
        repeat (50) @(negedge clk);
        check("no_queued_start", 32'({tx_busy, ps2_clk_low}), 0);

        for (int k = 0; k < 2; k++) begin
            d = 8'($urandom_range(0, 255));
            xfer(d, 1'($urandom_range(0, 1)));
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
